surf_cout_align: RTL and testbench

Automatic training controller that sits directly downstream of the SURF COUT PHY and closes its control loop. On request it sweeps the PHY's stacked-IDELAY range while the SURF transmits a fixed training nybble on COUT, finds the widest error-free window, parks the delay at the window centre, then bitslips the ISERDES until the captured nybble matches the pattern. It reports the result (eye start, width, chosen delay) to the TURFIO register space.

---
 rtl/surf_cout_align_pkg.sv | 42 ++++
 rtl/surf_cout_eye_tracker.sv | 72 +++++++
 rtl/surf_cout_align.sv | 200 ++++++++++++++++++++
 tb/tb_surf_cout_align.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/surf_cout_align_pkg.sv
// -----------------------------------------------------------------------------
// surf_cout_align_pkg
// Shared types and helpers for the SURF COUT training controller.
//   state_t            controller FSM states
//   MAX_LINEAR_DELAY   last linear tap visited by the scan (0..62)
//   lin_to_idelay()    linear tap -> PHY stacked-IDELAY encoding (skips 32)
//   is_rotation()      true when a nybble is any rotation of a pattern
// -----------------------------------------------------------------------------
package surf_cout_align_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SRST,
        S_SETTLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_EVAL,      // end of scan: tracker closes its run, result latched
        S_PARK,      // load the window centre
        S_PSETTLE,
        S_SLIP_CMP,
        S_SLIP_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [5:0] MAX_LINEAR_DELAY = 6'd62;

    // The stacked IDELAY has a duplicate code at 32, so linear taps at or
    // above 32 are shifted up by one and code 32 is never issued.
    function automatic logic [5:0] lin_to_idelay(input logic [5:0] d);
        return (d >= 6'd32) ? d + 6'd1 : d;
    endfunction

    function automatic logic is_rotation(input logic [3:0] v, input logic [3:0] p);
        return (v == p) ||
               (v == {p[2:0], p[3]}) ||
               (v == {p[1:0], p[3:2]}) ||
               (v == {p[0], p[3:1]});
    endfunction

endpackage

// File: rtl/surf_cout_eye_tracker.sv
// -----------------------------------------------------------------------------
// surf_cout_eye_tracker
// Tracks the longest contiguous run of passing taps during a delay scan.
// Ties keep the earlier run. The best-window outputs already account for a
// run that is still open, so the last tap of the scan is reflected without
// waiting for end_i.
// Ports:
//   sysclk_i, rst_i   clock, async active-high reset
//   clr_i             clear all state (start of a new scan)
//   tap_vld_i         one-cycle strobe: tap_pass_i/tap_idx_i are valid
//   tap_pass_i        tap result
//   tap_idx_i         linear tap index
//   end_i             end-of-scan strobe; closes any open run
//   best_start_o      first tap of the best window
//   best_width_o      width of the best window (0..63)
// -----------------------------------------------------------------------------
module surf_cout_eye_tracker
    import surf_cout_align_pkg::*;
(
    input  logic       sysclk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       tap_vld_i,
    input  logic       tap_pass_i,
    input  logic [5:0] tap_idx_i,
    input  logic       end_i,
    output logic [5:0] best_start_o,
    output logic [6:0] best_width_o
);

    logic [5:0] run_start_q, best_start_q;
    logic [6:0] run_len_q, best_width_q;
    logic       run_longer;

    // Strictly longer only, so an equal later run never displaces the first.
    assign run_longer   = run_len_q > best_width_q;
    assign best_start_o = run_longer ? run_start_q : best_start_q;
    assign best_width_o = run_longer ? run_len_q   : best_width_q;

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_width_q <= '0;
        end else if (clr_i) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_width_q <= '0;
        end else if (tap_vld_i) begin
            if (tap_pass_i) begin
                if (run_len_q == 7'd0)
                    run_start_q <= tap_idx_i;
                run_len_q <= run_len_q + 7'd1;
            end else begin
                if (run_longer) begin
                    best_start_q <= run_start_q;
                    best_width_q <= run_len_q;
                end
                run_len_q <= '0;
            end
        end else if (end_i) begin
            if (run_longer) begin
                best_start_q <= run_start_q;
                best_width_q <= run_len_q;
            end
            run_len_q <= '0;
        end
    end

endmodule

// File: rtl/surf_cout_align.sv
// -----------------------------------------------------------------------------
// surf_cout_align
// Training controller for the SURF COUT PHY. On start_i it resets the ISERDES,
// sweeps linear IDELAY taps 0..62 looking for the widest window where COUT
// holds a steady rotation of the training nybble, parks the delay at the
// window centre and bitslips (max 3) until the nybble matches exactly.
// Ports:
//   sysclk_i, rst_i        clock, async active-high reset
//   start_i                begin training (ignored while busy_o)
//   cout_i[3:0]            parallel COUT from the PHY
//   iserdes_rst_o          one-cycle ISERDES reset request
//   iserdes_bitslip_o      one-cycle bitslip pulse
//   idelay_value_o[5:0]    PHY-encoded IDELAY value (held between loads)
//   idelay_load_o          one-cycle load strobe, same cycle as new value
//   busy_o/done_o/fail_o   status
//   eye_start_o[5:0]       first linear tap of chosen window
//   eye_width_o[6:0]       width of chosen window
//   delay_o[5:0]           linear delay finally applied
// Build option: SURF_COUT_ALIGN_ILA_EN adds a surf_cout_align_ila debug core.
// -----------------------------------------------------------------------------
module surf_cout_align
    import surf_cout_align_pkg::*;
#(
    parameter logic [3:0] COUT_PATTERN  = 4'h8,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         CHECK_CYCLES  = 256,
    parameter int         BITSLIP_WAIT  = 8,
    parameter int         MIN_EYE       = 4
) (
    input  logic       sysclk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] cout_i,
    output logic       iserdes_rst_o,
    output logic       iserdes_bitslip_o,
    output logic [5:0] idelay_value_o,
    output logic       idelay_load_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fail_o,
    output logic [5:0] eye_start_o,
    output logic [6:0] eye_width_o,
    output logic [5:0] delay_o
);

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [5:0]  dly_q;
    logic [3:0]  ref_q;
    logic [1:0]  slip_q;
    logic [5:0]  trk_start, chosen;
    logic [6:0]  trk_width;
    logic        settle_done, slip_wait_done, check_ok, tap_end, tap_vld;
    logic        slip_match, eye_ok;

    assign settle_done    = cnt_q == 16'(SETTLE_CYCLES - 1);
    assign slip_wait_done = cnt_q == 16'(BITSLIP_WAIT - 1);
    // First CHECK cycle has no reference yet; after that the nybble must
    // also equal the previous cycle's value.
    assign check_ok   = is_rotation(cout_i, COUT_PATTERN) &&
                        ((cnt_q == 16'd0) || (cout_i == ref_q));
    assign tap_end    = !check_ok || (cnt_q == 16'(CHECK_CYCLES - 1));
    assign tap_vld    = (state_q == S_CHECK) && tap_end;
    assign slip_match = cout_i == COUT_PATTERN;
    assign eye_ok     = trk_width >= 7'(MIN_EYE);
    assign chosen     = trk_start + 6'(trk_width >> 1);

    surf_cout_eye_tracker u_trk (
        .sysclk_i     (sysclk_i),
        .rst_i        (rst_i),
        .clr_i        (state_q == S_SRST),
        .tap_vld_i    (tap_vld),
        .tap_pass_i   (check_ok),
        .tap_idx_i    (dly_q),
        .end_i        (state_q == S_EVAL),
        .best_start_o (trk_start),
        .best_width_o (trk_width)
    );

    // State and datapath registers
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            dly_q          <= '0;
            ref_q          <= '0;
            slip_q         <= '0;
            idelay_value_o <= '0;
            eye_start_o    <= '0;
            eye_width_o    <= '0;
            delay_o        <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change, so each timed state
            // counts from zero.
            cnt_q   <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
            if (state_q == S_CHECK)
                ref_q <= cout_i;
            case (state_q)
                S_SRST: begin
                    dly_q       <= '0;
                    slip_q      <= '0;
                    eye_start_o <= '0;
                    eye_width_o <= '0;
                    delay_o     <= '0;
                end
                S_SETTLE: begin
                    if (state_d == S_LOAD)
                        idelay_value_o <= lin_to_idelay(dly_q);
                end
                S_CHECK: begin
                    if (tap_end && (dly_q != MAX_LINEAR_DELAY)) begin
                        dly_q          <= dly_q + 6'd1;
                        idelay_value_o <= lin_to_idelay(dly_q + 6'd1);
                    end
                end
                S_EVAL: begin
                    eye_start_o <= trk_start;
                    eye_width_o <= trk_width;
                    if (eye_ok) begin
                        delay_o        <= chosen;
                        idelay_value_o <= lin_to_idelay(chosen);
                    end
                end
                S_SLIP_CMP: begin
                    if (iserdes_bitslip_o)
                        slip_q <= slip_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: if (start_i) state_d = S_SRST;
            S_SRST:      state_d = S_SETTLE;
            S_SETTLE:    if (settle_done) state_d = S_LOAD;
            S_LOAD:      state_d = S_WAIT;
            S_WAIT:      if (settle_done) state_d = S_CHECK;
            S_CHECK: begin
                if (tap_end)
                    state_d = (dly_q == MAX_LINEAR_DELAY) ? S_EVAL : S_LOAD;
            end
            S_EVAL:      state_d = eye_ok ? S_PARK : S_FAIL;
            S_PARK:      state_d = S_PSETTLE;
            S_PSETTLE:   if (settle_done) state_d = S_SLIP_CMP;
            S_SLIP_CMP: begin
                if (slip_match)
                    state_d = S_DONE;
                else if (slip_q == 2'd3)
                    state_d = S_FAIL;
                else
                    state_d = S_SLIP_WAIT;
            end
            S_SLIP_WAIT: if (slip_wait_done) state_d = S_SLIP_CMP;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        iserdes_rst_o     = 1'b0;
        iserdes_bitslip_o = 1'b0;
        idelay_load_o     = 1'b0;
        done_o            = 1'b0;
        fail_o            = 1'b0;
        busy_o            = 1'b1;
        case (state_q)
            S_IDLE:         busy_o = 1'b0;
            S_SRST:         iserdes_rst_o = 1'b1;
            S_LOAD, S_PARK: idelay_load_o = 1'b1;
            S_SLIP_CMP:     iserdes_bitslip_o = !slip_match && (slip_q != 2'd3);
            S_DONE: begin
                done_o = 1'b1;
                busy_o = 1'b0;
            end
            S_FAIL: begin
                fail_o = 1'b1;
                busy_o = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef SURF_COUT_ALIGN_ILA_EN
    surf_cout_align_ila u_ila (
        .clk    (sysclk_i),
        .probe0 (state_q),
        .probe1 (cout_i),
        .probe2 (dly_q),
        .probe3 (cnt_q),
        .probe4 (trk_start),
        .probe5 (trk_width)
    );
`endif

endmodule

// File: tb/tb_surf_cout_align.sv
// -----------------------------------------------------------------------------
// tb_surf_cout_align
// Directed bench: a small PHY model returns a steady rotation of the training
// nybble on taps inside configurable windows and 4'h5 elsewhere; bitslip
// pulses rotate the nybble one step toward the pattern.
// -----------------------------------------------------------------------------
module tb_surf_cout_align;

    localparam int SETTLE = 4;
    localparam int CHECKC = 16;
    localparam int BSW    = 8;
    localparam int MINE   = 4;

    logic       sysclk_i = 1'b0;
    logic       rst_i    = 1'b1;
    logic       start_i  = 1'b0;
    logic [3:0] cout_i;
    logic       iserdes_rst_o, iserdes_bitslip_o, idelay_load_o;
    logic [5:0] idelay_value_o, eye_start_o, delay_o;
    logic [6:0] eye_width_o;
    logic       busy_o, done_o, fail_o;

    always #5 sysclk_i = ~sysclk_i;

    surf_cout_align #(
        .COUT_PATTERN  (4'h8),
        .SETTLE_CYCLES (SETTLE),
        .CHECK_CYCLES  (CHECKC),
        .BITSLIP_WAIT  (BSW),
        .MIN_EYE       (MINE)
    ) dut (
        .sysclk_i          (sysclk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .cout_i            (cout_i),
        .iserdes_rst_o     (iserdes_rst_o),
        .iserdes_bitslip_o (iserdes_bitslip_o),
        .idelay_value_o    (idelay_value_o),
        .idelay_load_o     (idelay_load_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .fail_o            (fail_o),
        .eye_start_o       (eye_start_o),
        .eye_width_o       (eye_width_o),
        .delay_o           (delay_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // PHY model
    int         lo1 = 1, hi1 = 0, lo2 = 1, hi2 = 0;
    int         slip_init = 0;
    int         slips_seen = 0;
    int         cyc = 0, last_slip = 0, min_gap = 1000;
    logic       saw32 = 1'b0;
    logic [5:0] phy_lin = 6'd0;
    logic [1:0] off;
    logic       tap_pass;

    always @(posedge sysclk_i) begin
        cyc <= cyc + 1;
        if (start_i) begin
            slips_seen <= 0;
            min_gap    <= 1000;
            saw32      <= 1'b0;
        end
        if (idelay_load_o) begin
            phy_lin <= (idelay_value_o >= 6'd33) ? idelay_value_o - 6'd1 : idelay_value_o;
            if (idelay_value_o == 6'd32)
                saw32 <= 1'b1;
        end
        if (iserdes_bitslip_o) begin
            slips_seen <= slips_seen + 1;
            last_slip  <= cyc;
            if (slips_seen > 0 && (cyc - last_slip) < min_gap)
                min_gap <= cyc - last_slip;
        end
    end

    always_comb begin
        off      = 2'(slip_init - slips_seen);
        tap_pass = (int'(phy_lin) >= lo1 && int'(phy_lin) <= hi1) ||
                   (int'(phy_lin) >= lo2 && int'(phy_lin) <= hi2);
        cout_i   = tap_pass ? (4'h8 >> off) : 4'h5;
    end

    task automatic run_train(input string tag);
        bit fin;
        @(negedge sysclk_i) start_i = 1'b1;
        @(negedge sysclk_i) start_i = 1'b0;
        chk({tag, ".busy_rise"}, int'(busy_o), 1);
        fin = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge sysclk_i);
            if (done_o || fail_o) begin
                fin = 1'b1;
                break;
            end
        end
        chk({tag, ".finished"}, int'(fin), 1);
        chk({tag, ".busy_low"}, int'(busy_o), 0);
    endtask

    task automatic set_win(input int a, input int b, input int c, input int d, input int s);
        lo1 = a; hi1 = b; lo2 = c; hi2 = d; slip_init = s;
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge sysclk_i);
        chk("rst.busy", int'(busy_o), 0);
        chk("rst.done", int'(done_o), 0);
        chk("rst.fail", int'(fail_o), 0);
        chk("rst.value", int'(idelay_value_o), 0);
        chk("rst.width", int'(eye_width_o), 0);
        chk("rst.pulses", int'({iserdes_rst_o, idelay_load_o, iserdes_bitslip_o}), 0);
        rst_i = 1'b0;
        repeat (2) @(negedge sysclk_i);

        // Two windows, wider one first
        set_win(10, 24, 40, 45, 0);
        run_train("t1");
        chk("t1.done", int'(done_o), 1);
        chk("t1.fail", int'(fail_o), 0);
        chk("t1.eye_start", int'(eye_start_o), 10);
        chk("t1.eye_width", int'(eye_width_o), 15);
        chk("t1.delay", int'(delay_o), 17);
        chk("t1.idelay", int'(idelay_value_o), 17);
        chk("t1.slips", slips_seen, 0);

        // Window across the skipped code
        set_win(30, 36, 1, 0, 0);
        run_train("t2");
        chk("t2.done", int'(done_o), 1);
        chk("t2.eye_width", int'(eye_width_o), 7);
        chk("t2.delay", int'(delay_o), 33);
        chk("t2.idelay", int'(idelay_value_o), 34);
        chk("t2.no32", int'(saw32), 0);

        // Good eye, data three slips away
        set_win(20, 30, 1, 0, 3);
        run_train("t3");
        chk("t3.done", int'(done_o), 1);
        chk("t3.delay", int'(delay_o), 25);
        chk("t3.slips", slips_seen, 3);
        chk("t3.gap_ge9", int'(min_gap >= BSW + 1), 1);

        // No passing tap at all
        set_win(1, 0, 1, 0, 0);
        run_train("t4");
        chk("t4.fail", int'(fail_o), 1);
        chk("t4.done", int'(done_o), 0);
        chk("t4.eye_width", int'(eye_width_o), 0);
        chk("t4.slips", slips_seen, 0);

        // Equal-width runs: the earlier one wins
        set_win(5, 12, 50, 57, 0);
        run_train("t5");
        chk("t5.done", int'(done_o), 1);
        chk("t5.eye_start", int'(eye_start_o), 5);
        chk("t5.eye_width", int'(eye_width_o), 8);
        chk("t5.delay", int'(delay_o), 9);

        // Reset in the middle of a CHECK
        set_win(10, 24, 40, 45, 0);
        @(negedge sysclk_i) start_i = 1'b1;
        @(negedge sysclk_i) start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sysclk_i);
            if (idelay_load_o && idelay_value_o == 6'd12) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6.reach_tap12", int'(seen), 1);
        repeat (7) @(negedge sysclk_i);
        chk("t6.busy_pre", int'(busy_o), 1);
        rst_i = 1'b1;
        @(negedge sysclk_i);
        chk("t6.busy", int'(busy_o), 0);
        chk("t6.value", int'(idelay_value_o), 0);
        chk("t6.status", int'({done_o, fail_o}), 0);
        chk("t6.pulses", int'({iserdes_rst_o, idelay_load_o, iserdes_bitslip_o}), 0);
        rst_i = 1'b0;
        @(negedge sysclk_i);
        run_train("t6r");
        chk("t6r.done", int'(done_o), 1);
        chk("t6r.delay", int'(delay_o), 17);
        chk("t6r.idelay", int'(idelay_value_o), 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
